// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit-select datapath among four requesters.
// A winner holds the grant for a burst that ends on its LAST flag, on reaching
// MAX_BURST accepted beats, or when it withdraws its request. Every burst is
// followed by one IDLE cycle with GNT all zero before the next arbitration.
module mux41_rr_arbiter #(
  parameter int unsigned MAX_BURST = 8   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] REQ,
  input  logic [3:0] LAST,
  input  logic       READY,
  output logic [1:0] S,
  output logic [3:0] GNT,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic       valid_s;
  logic       accept_s;
  logic [3:0] cnt_inc_s;

  // First requester found scanning last+1, last+2, last+3, last+4 (mod 4).
  // The loop runs from the farthest position down so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // The owner's request qualifies the beat; non-owner requests are ignored.
  assign valid_s   = (state_q == XFER) && REQ[s_q];
  assign accept_s  = valid_s && READY;
  assign cnt_inc_s = cnt_q + 4'd1;

  assign S     = s_q;
  assign GNT   = gnt_q;
  assign VALID = valid_s;
  assign BUSY  = (state_q == XFER);

  // Next-state logic: arbitration in IDLE, beat counting and burst end in XFER.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (REQ != 4'b0000) begin
          s_d     = rr_pick(last_q, REQ);
          gnt_d   = onehot(rr_pick(last_q, REQ));
          cnt_d   = 4'd0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (accept_s) begin
          cnt_d = cnt_inc_s;
          if (LAST[s_q] || (cnt_inc_s == MAX_CNT)) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
            last_d  = s_q;
          end else begin
            state_d = XFER;
          end
        end else if (!REQ[s_q]) begin
          // Withdrawal: VALID is low, so no beat is lost.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = 4'd0;
          last_d  = s_q;
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 2'b00;
      gnt_q   <= 4'b0000;
      cnt_q   <= 4'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: one instance with MAX_BURST=8 and one
// with MAX_BURST=1 share the stimulus. Inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_mux41_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic       ready;

  logic [1:0] s8, s1;
  logic [3:0] gnt8, gnt1;
  logic       valid8, valid1;
  logic       busy8, busy1;

  int n_vec;
  int n_err;

  mux41_rr_arbiter #(.MAX_BURST(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .REQ(req), .LAST(last), .READY(ready),
    .S(s8), .GNT(gnt8), .VALID(valid8), .BUSY(busy8)
  );

  mux41_rr_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .REQ(req), .LAST(last), .READY(ready),
    .S(s1), .GNT(gnt1), .VALID(valid1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Full output view of the selected instance: {S, GNT, VALID, BUSY}.
  function automatic logic [7:0] view(input bit one);
    if (one) view = {s1, gnt1, valid1, busy1};
    else     view = {s8, gnt8, valid8, busy8};
  endfunction

  function automatic logic [7:0] granted(input logic [1:0] idx, input logic v);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    granted = {idx, oh, v, 1'b1};
  endfunction

  // n falling edges with requester idx granted and VALID high, then the IDLE gap.
  task automatic burst(input string tag, input bit one, input logic [1:0] idx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, view(one), granted(idx, 1'b1));
    end
    @(negedge clk);
    check({tag, "_gap"}, view(one), {idx, 4'b0000, 1'b0, 1'b0});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    last  = 4'b0000;
    ready = 1'b0;
    #12;
    check("reset8", view(1'b0), 8'b00_0000_0_0);
    check("reset1", view(1'b1), 8'b00_0000_0_0);

    // Round-robin over all four with full-length bursts.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    burst("rr0", 1'b0, 2'd0, 8);
    burst("rr1", 1'b0, 2'd1, 8);
    burst("rr2", 1'b0, 2'd2, 8);
    burst("rr3", 1'b0, 2'd3, 8);
    burst("rr0b", 1'b0, 2'd0, 8);

    // LAST pulsed on the third beat ends the burst after 3 beats.
    req = 4'b0100;
    @(negedge clk);
    check("last_b1", view(1'b0), granted(2'd2, 1'b1));
    @(negedge clk);
    check("last_b2", view(1'b0), granted(2'd2, 1'b1));
    @(negedge clk);
    check("last_b3", view(1'b0), granted(2'd2, 1'b1));
    last = 4'b0100;
    @(negedge clk);
    check("last_gap", view(1'b0), 8'b10_0000_0_0);
    last = 4'b0000;
    @(negedge clk);
    check("last_regrant", view(1'b0), granted(2'd2, 1'b1));
    req = 4'b0000;
    #1;
    check("wd2_valid", view(1'b0), granted(2'd2, 1'b0));
    @(negedge clk);
    check("wd2_gap", view(1'b0), 8'b10_0000_0_0);

    // READY low for 5 cycles freezes the count; 8 beats follow.
    req   = 4'b0010;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold", view(1'b0), granted(2'd1, 1'b1));
    end
    ready = 1'b1;
    burst("hold_rest", 1'b0, 2'd1, 7);

    // Requester 3 withdraws after 2 beats; pending requester 0 is next.
    req = 4'b1000;
    @(negedge clk);
    check("wd3_b1", view(1'b0), granted(2'd3, 1'b1));
    @(negedge clk);
    check("wd3_b2", view(1'b0), granted(2'd3, 1'b1));
    @(negedge clk);
    check("wd3_b3", view(1'b0), granted(2'd3, 1'b1));
    req = 4'b0001;
    #1;
    check("wd3_valid", view(1'b0), granted(2'd3, 1'b0));
    @(negedge clk);
    check("wd3_gap", view(1'b0), 8'b11_0000_0_0);
    @(negedge clk);
    check("wd3_next", view(1'b0), granted(2'd0, 1'b1));

    // Reset asserted mid-burst while requester 2 owns the grant.
    req = 4'b0100;
    @(negedge clk);
    check("pre_rst_gap", view(1'b0), 8'b00_0000_0_0);
    @(negedge clk);
    check("pre_rst_own", view(1'b0), granted(2'd2, 1'b1));
    @(negedge clk);
    check("pre_rst_own2", view(1'b0), granted(2'd2, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", view(1'b0), 8'b00_0000_0_0);
    req = 4'b1111;
    @(negedge clk);
    check("rst_held", view(1'b0), 8'b00_0000_0_0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", view(1'b0), granted(2'd0, 1'b1));

    // MAX_BURST=1 instance: alternating single-beat grants 1,3,1,3.
    rst_n = 1'b0;
    req   = 4'b1010;
    ready = 1'b1;
    last  = 4'b0000;
    @(negedge clk);
    check("mb1_reset", view(1'b1), 8'b00_0000_0_0);
    rst_n = 1'b1;
    burst("mb1_a", 1'b1, 2'd1, 1);
    burst("mb1_b", 1'b1, 2'd3, 1);
    burst("mb1_c", 1'b1, 2'd1, 1);
    burst("mb1_d", 1'b1, 2'd3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
